// File: rtl/ex_pkg.sv
// Shared opcode/funct codes, instruction-type codes and muldiv FSM states for the execute stage.
package ex_pkg;

  localparam logic [1:0] ITYPE_R   = 2'b00;
  localparam logic [1:0] ITYPE_I   = 2'b01;
  localparam logic [1:0] ITYPE_J   = 2'b10;
  localparam logic [1:0] ITYPE_RSV = 2'b11;

  localparam logic [5:0] OPC_ADDI = 6'h08;
  localparam logic [5:0] OPC_SLTI = 6'h0A;
  localparam logic [5:0] OPC_ANDI = 6'h0C;
  localparam logic [5:0] OPC_ORI  = 6'h0D;
  localparam logic [5:0] OPC_LW   = 6'h23;
  localparam logic [5:0] OPC_SW   = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIVU = 6'h1B;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } md_state_e;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative signed multiply (shift-add) and unsigned restoring divide, one bit per cycle.
// HI/LO update on the last busy cycle; instantiated only when MULDIV_EN is defined.
module ex_muldiv
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              is_div_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int unsigned     CntW    = $clog2(DATA_W);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  md_state_e             state_q;
  logic [CntW-1:0]       cnt_q;
  logic                  is_div_q;
  logic [2*DATA_W-1:0]   acc_q;
  logic [2*DATA_W-1:0]   mcand_q;
  logic [DATA_W-1:0]     mplier_q;
  logic [DATA_W-1:0]     hi_q;
  logic [DATA_W-1:0]     lo_q;

  logic [2*DATA_W-1:0]   acc_step;
  logic [DATA_W:0]       rem_sh;
  logic [DATA_W:0]       rem_sub;
  logic [DATA_W-1:0]     quot_sh;

  // Divide keeps {remainder, quotient} in acc_q; a zero divisor naturally yields all-ones / dividend.
  always_comb begin
    rem_sh   = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    rem_sub  = rem_sh - {1'b0, mcand_q[DATA_W-1:0]};
    quot_sh  = {acc_q[DATA_W-2:0], 1'b0};
    acc_step = acc_q;
    if (is_div_q) begin
      if (rem_sh >= {1'b0, mcand_q[DATA_W-1:0]}) begin
        acc_step = {rem_sub[DATA_W-1:0], quot_sh[DATA_W-1:1], 1'b1};
      end else begin
        acc_step = {rem_sh[DATA_W-1:0], quot_sh};
      end
    end else if (mplier_q[0]) begin
      // The multiplier's sign bit carries negative weight in two's complement.
      acc_step = (cnt_q == CntLast) ? acc_q - mcand_q : acc_q + mcand_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q  <= StBusy;
            cnt_q    <= '0;
            is_div_q <= is_div_i;
            mplier_q <= b_i;
            if (is_div_i) begin
              acc_q   <= {{DATA_W{1'b0}}, a_i};
              mcand_q <= {{DATA_W{1'b0}}, b_i};
            end else begin
              acc_q   <= '0;
              mcand_q <= {{DATA_W{a_i[DATA_W-1]}}, a_i};
            end
          end
        end
        StBusy: begin
          acc_q    <= acc_step;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CntW'(1);
          if (!is_div_q) begin
            mcand_q <= mcand_q << 1;
          end
          if (cnt_q == CntLast) begin
            state_q <= StIdle;
            hi_q    <= acc_step[2*DATA_W-1:DATA_W];
            lo_q    <= acc_step[DATA_W-1:0];
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o = (state_q == StBusy);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/ex_stage.sv
// MIPS-32 execute stage: immediate extension, ALU, control decode and the EX/MEM register.
// Define MULDIV_EN to build the iterative MULT/DIVU unit; otherwise those ops are NOPs.
module ex_stage
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned IMM_W      = 15,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  input  logic [5:0]            opcode_i,
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic [REG_ADDR_W-1:0] rt_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic [4:0]            sa_i,
  input  logic [5:0]            funct_i,
  input  logic [IMM_W-1:0]      imm_i,
  input  logic [1:0]            instr_type_i,
  input  logic [DATA_W-1:0]     rs_val_i,
  input  logic [DATA_W-1:0]     rt_val_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  out_valid_o,
  output logic [DATA_W-1:0]     alu_result_o,
  output logic [DATA_W-1:0]     store_data_o,
  output logic [REG_ADDR_W-1:0] dest_reg_o,
  output logic                  reg_write_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic                  overflow_o
);

  logic                  accept, md_start, md_busy, is_md;
  logic [DATA_W-1:0]     hi, lo;
  logic [DATA_W-1:0]     imm_sx, imm_zx, sum_rr, dif_rr, sum_ri;
  logic                  ovf_add, ovf_sub, ovf_addi, slt_rr, slt_ri;
  logic [DATA_W-1:0]     res_d, sd_d;
  logic [REG_ADDR_W-1:0] dest_d;
  logic                  rw_d, mr_d, mw_d, ovf_d;

  logic                  valid_q, rw_q, mr_q, mw_q, ovf_q;
  logic [DATA_W-1:0]     res_q, sd_q;
  logic [REG_ADDR_W-1:0] dest_q;

  // Operands arrive as values; the rs index itself is not needed here.
  logic unused_rs;
  assign unused_rs = ^rs_i;

  assign imm_sx   = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};
  assign imm_zx   = {{(DATA_W-IMM_W){1'b0}}, imm_i};
  assign sum_rr   = rs_val_i + rt_val_i;
  assign dif_rr   = rs_val_i - rt_val_i;
  assign sum_ri   = rs_val_i + imm_sx;
  assign ovf_add  = (rs_val_i[DATA_W-1] == rt_val_i[DATA_W-1]) &&
                    (sum_rr[DATA_W-1] != rs_val_i[DATA_W-1]);
  assign ovf_sub  = (rs_val_i[DATA_W-1] != rt_val_i[DATA_W-1]) &&
                    (dif_rr[DATA_W-1] != rs_val_i[DATA_W-1]);
  assign ovf_addi = (rs_val_i[DATA_W-1] == imm_sx[DATA_W-1]) &&
                    (sum_ri[DATA_W-1] != rs_val_i[DATA_W-1]);
  assign slt_rr   = $signed(rs_val_i) < $signed(rt_val_i);
  assign slt_ri   = $signed(rs_val_i) < $signed(imm_sx);

  always_comb begin
    res_d  = '0;
    sd_d   = '0;
    dest_d = '0;
    rw_d   = 1'b0;
    mr_d   = 1'b0;
    mw_d   = 1'b0;
    ovf_d  = 1'b0;
    is_md  = 1'b0;
    unique case (instr_type_i)
      ITYPE_R: begin
        dest_d = rd_i;
        unique case (funct_i)
          FN_ADD:  begin res_d = sum_rr; ovf_d = ovf_add; rw_d = !ovf_add; end
          FN_SUB:  begin res_d = dif_rr; ovf_d = ovf_sub; rw_d = !ovf_sub; end
          FN_AND:  begin res_d = rs_val_i & rt_val_i;    rw_d = 1'b1; end
          FN_OR:   begin res_d = rs_val_i | rt_val_i;    rw_d = 1'b1; end
          FN_XOR:  begin res_d = rs_val_i ^ rt_val_i;    rw_d = 1'b1; end
          FN_NOR:  begin res_d = ~(rs_val_i | rt_val_i); rw_d = 1'b1; end
          FN_SLT:  begin res_d = {{(DATA_W-1){1'b0}}, slt_rr}; rw_d = 1'b1; end
          FN_SLL:  begin res_d = rt_val_i << sa_i;  rw_d = 1'b1; end
          FN_SRL:  begin res_d = rt_val_i >> sa_i;  rw_d = 1'b1; end
          FN_SRA:  begin res_d = $signed(rt_val_i) >>> sa_i; rw_d = 1'b1; end
          FN_MFHI: begin res_d = hi; rw_d = 1'b1; end
          FN_MFLO: begin res_d = lo; rw_d = 1'b1; end
          FN_MULT, FN_DIVU: is_md = 1'b1;
          default: ;
        endcase
      end
      ITYPE_I: begin
        dest_d = rt_i;
        unique case (opcode_i)
          OPC_ADDI: begin res_d = sum_ri; ovf_d = ovf_addi; rw_d = !ovf_addi; end
          OPC_SLTI: begin res_d = {{(DATA_W-1){1'b0}}, slt_ri}; rw_d = 1'b1; end
          OPC_ANDI: begin res_d = rs_val_i & imm_zx; rw_d = 1'b1; end
          OPC_ORI:  begin res_d = rs_val_i | imm_zx; rw_d = 1'b1; end
          OPC_LW:   begin res_d = sum_ri; mr_d = 1'b1; rw_d = 1'b1; end
          OPC_SW:   begin res_d = sum_ri; sd_d = rt_val_i; mw_d = 1'b1; end
          default: ;
        endcase
      end
      ITYPE_J, ITYPE_RSV: ;
    endcase
    if (dest_d == '0) begin
      rw_d = 1'b0;
    end
  end

  assign accept   = in_valid_i && !stall_o;
  assign md_start = accept && !flush_i && is_md;

`ifdef MULDIV_EN
  ex_muldiv #(
    .DATA_W(DATA_W)
  ) u_muldiv (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (md_start),
    .is_div_i(funct_i == FN_DIVU),
    .a_i     (rs_val_i),
    .b_i     (rt_val_i),
    .busy_o  (md_busy),
    .hi_o    (hi),
    .lo_o    (lo)
  );
  assign stall_o = md_busy;
`else
  logic unused_md;
  assign unused_md = md_start;
  assign md_busy   = 1'b0;
  assign hi        = '0;
  assign lo        = '0;
  assign stall_o   = md_busy;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      sd_q    <= '0;
      dest_q  <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept && !flush_i) begin
      valid_q <= 1'b1;
      res_q   <= res_d;
      sd_q    <= sd_d;
      dest_q  <= dest_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      ovf_q   <= ovf_d;
    end else begin
      valid_q <= 1'b0;
      res_q   <= '0;
      sd_q    <= '0;
      dest_q  <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end
  end

  assign out_valid_o  = valid_q;
  assign alu_result_o = res_q;
  assign store_data_o = sd_q;
  assign dest_reg_o   = dest_q;
  assign reg_write_o  = rw_q;
  assign mem_read_o   = mr_q;
  assign mem_write_o  = mw_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed literal checks plus randomized traffic against a behavioural model.
module tb_ex_stage;

  localparam int unsigned DW = 32;
`ifdef MULDIV_EN
  localparam bit MdEn = 1'b1;
`else
  localparam bit MdEn = 1'b0;
`endif

  logic        clk, rst, in_valid, flush;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, sa;
  logic [14:0] imm;
  logic [1:0]  instr_type;
  logic [31:0] rs_val, rt_val;
  logic        stall, out_valid, reg_write, mem_read, mem_write, overflow;
  logic [31:0] alu_result, store_data;
  logic [4:0]  dest_reg;

  ex_stage dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .opcode_i    (opcode),
    .rs_i        (rs),
    .rt_i        (rt),
    .rd_i        (rd),
    .sa_i        (sa),
    .funct_i     (funct),
    .imm_i       (imm),
    .instr_type_i(instr_type),
    .rs_val_i    (rs_val),
    .rt_val_i    (rt_val),
    .flush_i     (flush),
    .stall_o     (stall),
    .out_valid_o (out_valid),
    .alu_result_o(alu_result),
    .store_data_o(store_data),
    .dest_reg_o  (dest_reg),
    .reg_write_o (reg_write),
    .mem_read_o  (mem_read),
    .mem_write_o (mem_write),
    .overflow_o  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        v;
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  dest;
    logic        rw, mr, mw, ovf;
  } slot_t;

  // Reference model state: cycles of stall still owed and the architectural HI/LO.
  int          busy_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  slot_t       exp_s = '0;

  function automatic slot_t ref_slot(input logic [31:0] hi_v, input logic [31:0] lo_v);
    slot_t       s;
    longint      sum;
    int          imm_s;
    logic [31:0] imm_z;
    s     = '0;
    s.v   = 1'b1;
    imm_s = int'($signed(imm));
    imm_z = {17'b0, imm};
    if (instr_type == 2'b00) begin
      s.dest = rd;
      case (funct)
        6'h20, 6'h22: begin
          if (funct == 6'h20) sum = longint'($signed(rs_val)) + longint'($signed(rt_val));
          else                sum = longint'($signed(rs_val)) - longint'($signed(rt_val));
          s.res = sum[31:0];
          s.ovf = (sum > longint'(32'h7FFFFFFF)) || (sum < -longint'(32'h80000000));
          s.rw  = !s.ovf;
        end
        6'h24: begin s.res = rs_val & rt_val;    s.rw = 1; end
        6'h25: begin s.res = rs_val | rt_val;    s.rw = 1; end
        6'h26: begin s.res = rs_val ^ rt_val;    s.rw = 1; end
        6'h27: begin s.res = ~(rs_val | rt_val); s.rw = 1; end
        6'h2A: begin s.res = ($signed(rs_val) < $signed(rt_val)) ? 32'd1 : 32'd0; s.rw = 1; end
        6'h00: begin s.res = rt_val << sa; s.rw = 1; end
        6'h02: begin s.res = rt_val >> sa; s.rw = 1; end
        6'h03: begin s.res = $unsigned($signed(rt_val) >>> sa); s.rw = 1; end
        6'h10: begin s.res = hi_v; s.rw = 1; end
        6'h12: begin s.res = lo_v; s.rw = 1; end
        default: ;
      endcase
    end else if (instr_type == 2'b01) begin
      s.dest = rt;
      case (opcode)
        6'h08: begin
          sum   = longint'($signed(rs_val)) + longint'(imm_s);
          s.res = sum[31:0];
          s.ovf = (sum > longint'(32'h7FFFFFFF)) || (sum < -longint'(32'h80000000));
          s.rw  = !s.ovf;
        end
        6'h0A: begin s.res = (int'($signed(rs_val)) < imm_s) ? 32'd1 : 32'd0; s.rw = 1; end
        6'h0C: begin s.res = rs_val & imm_z; s.rw = 1; end
        6'h0D: begin s.res = rs_val | imm_z; s.rw = 1; end
        6'h23: begin s.res = rs_val + 32'(imm_s); s.mr = 1; s.rw = 1; end
        6'h2B: begin s.res = rs_val + 32'(imm_s); s.sd = rt_val; s.mw = 1; end
        default: ;
      endcase
    end
    if (s.dest == 5'd0) s.rw = 1'b0;
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic   acc, is_md;
    longint prod;
    if (rst) begin
      busy_left = 0;
      m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0;
      exp_s = '0;
    end else begin
      acc   = in_valid && (busy_left == 0);
      is_md = (instr_type == 2'b00) && (funct == 6'h18 || funct == 6'h1B);
      exp_s = (acc && !flush) ? ref_slot(m_hi, m_lo) : '0;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
      end
      if (MdEn && acc && !flush && is_md) begin
        busy_left = DW;
        if (funct == 6'h18) begin
          prod = longint'($signed(rs_val)) * longint'($signed(rt_val));
          p_hi = prod[63:32];
          p_lo = prod[31:0];
        end else if (rt_val == 0) begin
          p_lo = 32'hFFFFFFFF;
          p_hi = rs_val;
        end else begin
          p_lo = rs_val / rt_val;
          p_hi = rs_val % rt_val;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("stall",      stall,      busy_left > 0);
    chk("out_valid",  out_valid,  exp_s.v);
    chk("alu_result", alu_result, exp_s.res);
    chk("store_data", store_data, exp_s.sd);
    chk("dest_reg",   dest_reg,   exp_s.dest);
    chk("reg_write",  reg_write,  exp_s.rw);
    chk("mem_read",   mem_read,   exp_s.mr);
    chk("mem_write",  mem_write,  exp_s.mw);
    chk("overflow",   overflow,   exp_s.ovf);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] ty, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rt_a, input logic [4:0] rd_a, input logic [14:0] im,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; flush = 1'b0; instr_type = ty; opcode = op; funct = fn;
    rs = 5'd1; rt = rt_a; rd = rd_a; sa = 5'd0; imm = im; rs_val = a; rt_val = b;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  // Hold the driven instruction until the stage takes it; returns the stalled cycles.
  task automatic hold(output int stalls);
    stalls = 0;
    while (stall && stalls < 200) begin
      step();
      stalls++;
    end
    step();
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'hFFFFFFFF;
      5: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  logic [5:0] fn_tab [16] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00,
                              6'h02, 6'h03, 6'h10, 6'h12, 6'h18, 6'h1B, 6'h3F, 6'h11};
  logic [5:0] op_tab [8]  = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h3E, 6'h04};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 1000000", $time);
    $fatal(1);
  end

  initial begin
    int st;
    rst = 1'b0;
    idle();
    instr_type = 2'b00; opcode = '0; funct = '0; rs = '0; rt = '0; rd = '0;
    sa = '0; imm = '0; rs_val = '0; rt_val = '0;
    #1 rst = 1'b1;
    #2;
    chk("reset_valid", out_valid, 0);
    chk("reset_stall", stall, 0);
    step(); step();
    rst = 1'b0;

    drive(2'b00, 6'h00, 6'h20, 5'd0, 5'd3, 15'h0, 32'd5, 32'd7); step();
    chk("add_res", alu_result, 12);
    chk("add_dest", dest_reg, 3);
    chk("add_rw", reg_write, 1);
    chk("add_valid", out_valid, 1);

    drive(2'b00, 6'h00, 6'h20, 5'd0, 5'd4, 15'h0, 32'h7FFFFFFF, 32'h1); step();
    chk("addovf_res", alu_result, 32'h80000000);
    chk("addovf_ovf", overflow, 1);
    chk("addovf_rw", reg_write, 0);

    drive(2'b01, 6'h23, 6'h00, 5'd9, 5'd0, 15'h7FFC, 32'h100, 32'h0); step();
    chk("lw_addr", alu_result, 32'h000000FC);
    chk("lw_mr", mem_read, 1);
    chk("lw_dest", dest_reg, 9);

    drive(2'b00, 6'h00, 6'h18, 5'd2, 5'd0, 15'h0, 32'h0000FFFF, 32'h00010001); step();
    chk("mult_valid", out_valid, 1);
    chk("mult_rw", reg_write, 0);
    drive(2'b00, 6'h00, 6'h12, 5'd0, 5'd2, 15'h0, 32'h0, 32'h0); hold(st);
    chk("mult_stall_cycles", st, MdEn ? 32 : 0);
    chk("mult_lo", alu_result, MdEn ? 32'hFFFFFFFF : 32'h0);
    drive(2'b00, 6'h00, 6'h10, 5'd0, 5'd2, 15'h0, 32'h0, 32'h0); hold(st);
    chk("mult_hi", alu_result, 0);

    drive(2'b00, 6'h00, 6'h1B, 5'd2, 5'd0, 15'h0, 32'd7, 32'd0); step();
    drive(2'b00, 6'h00, 6'h10, 5'd0, 5'd5, 15'h0, 32'h0, 32'h0); hold(st);
    chk("div0_stall_cycles", st, MdEn ? 32 : 0);
    chk("div0_hi", alu_result, MdEn ? 32'd7 : 32'd0);
    drive(2'b00, 6'h00, 6'h12, 5'd0, 5'd5, 15'h0, 32'h0, 32'h0); hold(st);
    chk("div0_lo", alu_result, MdEn ? 32'hFFFFFFFF : 32'h0);

    drive(2'b00, 6'h00, 6'h1B, 5'd2, 5'd0, 15'h0, 32'd17, 32'd5); step();
    drive(2'b00, 6'h00, 6'h12, 5'd0, 5'd6, 15'h0, 32'h0, 32'h0); hold(st);
    chk("div_lo", alu_result, MdEn ? 32'd3 : 32'd0);
    drive(2'b00, 6'h00, 6'h10, 5'd0, 5'd6, 15'h0, 32'h0, 32'h0); hold(st);
    chk("div_hi", alu_result, MdEn ? 32'd2 : 32'd0);

    drive(2'b00, 6'h00, 6'h18, 5'd2, 5'd0, 15'h0, 32'h12345, 32'hFFFF0000); step();
    idle();
    repeat (10) step();
    chk("busy_before_rst", stall, MdEn ? 1 : 0);
    rst = 1'b1;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_valid", out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(2'b00, 6'h00, 6'h10, 5'd0, 5'd7, 15'h0, 32'h0, 32'h0); hold(st);
    chk("rst_mfhi", alu_result, 0);

    drive(2'b00, 6'h00, 6'h18, 5'd2, 5'd0, 15'h0, 32'd3, 32'd4);
    flush = 1'b1;
    step();
    chk("flush_mult_stall", stall, 0);
    chk("flush_mult_valid", out_valid, 0);

    for (int i = 0; i < 2500; i++) begin
      in_valid   = ($urandom_range(0, 9) < 8);
      flush      = ($urandom_range(0, 9) == 0);
      instr_type = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) instr_type = 2'b00;
      funct  = fn_tab[$urandom_range(0, 15)];
      opcode = op_tab[$urandom_range(0, 7)];
      rs     = 5'($urandom);
      rt     = 5'($urandom);
      rd     = 5'($urandom);
      sa     = 5'($urandom);
      imm    = 15'($urandom);
      rs_val = pick_val();
      rt_val = pick_val();
      step();
    end

    idle();
    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
